pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the fetch stage. It owns the fetch PC that addresses instruction memory, a 4096-word ROM based at 0x00003000 and indexed by `(pc - 0x3000)[13:2]`. Each cycle it picks the next PC from sequential, branch/jump, exception-vector and ERET sources. It handles pipeline stalls and defers redirects that arrive while the pipeline is stalled. It also flags fetch-address errors (AdEL) before the memory is read.

## Interface
Parameters:
- `RESET_PC`, default 32'h00003000, first fetch address after reset.
- `EXC_VEC`, default 32'h00004180, exception handler entry.
- `IM_WORDS`, default 4096, instruction-memory depth in words. Legal fetch range is `[RESET_PC, RESET_PC + 4*IM_WORDS - 4]`.

Ports:
- `clk`, input, 1, sole clock, rising edge.
- `reset`, input, 1, synchronous, active-high.
- `stall`, input, 1, hazard unit holds the IF stage.
- `br_valid`, input, 1, branch/jump taken, from ID.
- `br_target`, input, 32, redirect target.
- `exc_req`, input, 1, exception/interrupt commit, from CP0.
- `eret_req`, input, 1, ERET commit.
- `epc`, input, 32, return address for ERET.
- `pc`, output, 32, current fetch address, registered.
- `pc_plus4`, output, 32, `pc + 4`, combinational, wraps modulo 2^32.
- `fetch_valid`, output, 1, the instruction at `pc` is to be issued to IF/ID.
- `fetch_adel`, output, 1, `pc` is misaligned or out of range.
- `redir_pending`, output, 1, a deferred redirect is held.

## Operation
- FSM states are BOOT, RUN and FLUSH. Reset enters BOOT.
- BOOT: `fetch_valid`=0 for one cycle, `pc`=RESET_PC, then go to RUN.
- RUN: `fetch_valid`=~`fetch_adel`. The next PC is chosen by strict priority:
  1. `exc_req`: EXC_VEC. Go to FLUSH and clear the pending redirect.
  2. `eret_req`: `epc`. Go to FLUSH and clear the pending redirect.
  3. `stall`: hold `pc`. If `br_valid`, latch `br_target` into the pending register and set `redir_pending`. A later `br_valid` during the same stall overwrites the pending target.
  4. `br_valid`: `br_target`.
  5. Pending set: pending target, and clear pending.
  6. Otherwise: `pc_plus4`.
- FLUSH: `fetch_valid`=0 for one cycle with `pc` already at the new target, then go to RUN. `exc_req` during FLUSH re-vectors to EXC_VEC and stays in FLUSH.
- `exc_req` and `eret_req` override `stall`. `exc_req` overrides `eret_req`.
- `fetch_adel`=1 when `pc[1:0]!=0`, `pc<RESET_PC`, or `pc>RESET_PC+4*IM_WORDS-4`. Compute it with 32-bit unsigned compares.
- While `fetch_adel`=1, `fetch_valid`=0 and the PC keeps advancing per the priority rules. CP0 raises `exc_req` in response.

## Timing
- All requests are sampled at the rising edge and take effect on `pc` in the next cycle. Redirect latency is 1 cycle.
- Reset values: `pc`=RESET_PC, `fetch_valid`=0, `redir_pending`=0, `fetch_adel`=0, state BOOT.
- `reset` asserted mid-operation wins over every request, including `exc_req`, in the same edge.
- A deferred redirect is applied on the first edge where `stall`=0, unless `br_valid` is high on that edge; the new branch wins and pending clears.
- No combinational path from any input to `pc`, `fetch_valid` or `redir_pending`. `fetch_adel` and `pc_plus4` depend only on `pc`.

## Structure
- Shared package `cpu_pkg`:
  - address constants 32'h00003000 and 32'h00004180 and the IM_WORDS default;
  - state encoding: BOOT=2'd0, RUN=2'd1, FLUSH=2'd2.
- One sub-module is natural: `pc_range_chk`, the pure combinational alignment and range check that drives `fetch_adel`.
- The rest is a single `always @(posedge clk)` for `pc`, the pending register and the FSM, plus a combinational next-PC mux.

## Test plan
- Reset, then free run: `pc` sequence 0x3000 (valid=0), 0x3000 (valid=1), 0x3004, 0x3008.
- At pc=0x3010, `br_valid`=1 with target 0x3100: next `pc`=0x3100 and `fetch_valid` stays 1.
- At pc=0x3020, `stall` for 3 cycles with `br_valid`=1 and target 0x3200 in the first stall cycle: `pc` holds 0x3020 and `redir_pending`=1. First unstalled edge gives `pc`=0x3200 and `redir_pending`=0.
- `exc_req` during `stall` with a pending redirect: `pc`=0x4180, `fetch_valid`=0 for one cycle, pending cleared. Then `eret_req` with `epc`=0x3024 gives `pc`=0x3024 after one flush cycle.
- `br_target`=0x3002, then 0x7000, then 0x2FFC: `fetch_adel`=1 and `fetch_valid`=0 for each. Target 0x6FFC gives `fetch_adel`=0.
- `reset` asserted on the same edge as `exc_req` at pc=0x3500: `pc`=0x3000 and state BOOT.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch address map defaults and the sequencer state encoding.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h0000_4180;
    localparam int          IM_WORDS_DEFAULT = 4096;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } seq_state_t;

    // Address of the last word in an instruction memory of 'words' words at 'base'.
    function automatic logic [31:0] im_last_addr(input logic [31:0] base, input int words);
        return base + (32'(words) << 2) - 32'd4;
    endfunction

endpackage

// File: rtl/pc_range_chk.sv
// Fetch-address error check: flags a PC that is misaligned or outside the instruction memory.
module pc_range_chk
    import cpu_pkg::*;
#(
    parameter logic [31:0] BASE  = RESET_PC_DEFAULT,
    parameter int          WORDS = IM_WORDS_DEFAULT
) (
    input  logic [31:0] pc,
    output logic        adel
);

    localparam logic [31:0] LAST = im_last_addr(BASE, WORDS);

    assign adel = (pc[1:0] != 2'b00) || (pc < BASE) || (pc > LAST);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: next-PC selection, stall handling with
// deferred redirects, exception/ERET flushes and fetch-address error flagging.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEFAULT,
    parameter int          IM_WORDS = IM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        fetch_adel,
    output logic        redir_pending
);

    seq_state_t  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        pend_valid_reg, pend_valid_next;
    logic [31:0] pend_target_reg, pend_target_next;
    logic        adel;

    pc_range_chk #(
        .BASE  (RESET_PC),
        .WORDS (IM_WORDS)
    ) u_range_chk (
        .pc   (pc_reg),
        .adel (adel)
    );

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        pend_valid_next  = pend_valid_reg;
        pend_target_next = pend_target_reg;
        case (state_reg)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (exc_req) begin
                    pc_next         = EXC_VEC;
                    state_next      = FLUSH;
                    pend_valid_next = 1'b0;
                end else if (eret_req) begin
                    pc_next         = epc;
                    state_next      = FLUSH;
                    pend_valid_next = 1'b0;
                end else if (stall) begin
                    // Redirects seen while stalled are parked; the newest one wins.
                    if (br_valid) begin
                        pend_valid_next  = 1'b1;
                        pend_target_next = br_target;
                    end
                end else if (br_valid) begin
                    pc_next         = br_target;
                    pend_valid_next = 1'b0;
                end else if (pend_valid_reg) begin
                    pc_next         = pend_target_reg;
                    pend_valid_next = 1'b0;
                end else begin
                    pc_next = pc_plus4;
                end
            end
            FLUSH: begin
                // The target fetched in this bubble is issued on the next RUN cycle.
                if (exc_req) begin
                    pc_next = EXC_VEC;
                end else begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= BOOT;
            pc_reg          <= RESET_PC;
            pend_valid_reg  <= 1'b0;
            pend_target_reg <= RESET_PC;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            pend_valid_reg  <= pend_valid_next;
            pend_target_reg <= pend_target_next;
        end
    end

    assign pc            = pc_reg;
    assign pc_plus4      = pc_reg + 32'd4;
    assign fetch_adel    = adel;
    assign fetch_valid   = (state_reg == RUN) && !adel;
    assign redir_pending = pend_valid_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each scenario queues stimulus with its expected
// post-edge state, drives it cycle by cycle and compares after every rising edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, stall, br_valid, exc_req, eret_req;
    logic [31:0] br_target, epc;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, fetch_adel, redir_pending;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .br_valid      (br_valid),
        .br_target     (br_target),
        .exc_req       (exc_req),
        .eret_req      (eret_req),
        .epc           (epc),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .fetch_adel    (fetch_adel),
        .redir_pending (redir_pending)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        fv;
        logic        adel;
        logic        pend;
    } exp_t;

    typedef struct {
        string       name;
        logic        rst;
        logic        st;
        logic        bv;
        logic [31:0] bt;
        logic        ex;
        logic        er;
        logic [31:0] ep;
        exp_t        exp;
    } stim_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic void add(input string nm, input logic rst, input logic st,
                                input logic bv, input logic [31:0] bt, input logic ex,
                                input logic er, input logic [31:0] ep, input logic [31:0] xpc,
                                input logic xfv, input logic xadel, input logic xpend);
        stim_t s;
        s.name = nm; s.rst = rst; s.st = st; s.bv = bv; s.bt = bt;
        s.ex = ex; s.er = er; s.ep = ep;
        s.exp = '{pc: xpc, fv: xfv, adel: xadel, pend: xpend};
        stim_q.push_back(s);
    endfunction

    task automatic drive(input stim_t s);
        @(negedge clk);
        reset = s.rst; stall = s.st; br_valid = s.bv; br_target = s.bt;
        exc_req = s.ex; eret_req = s.er; epc = s.ep;
        exp_q.push_back(s.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s; exp_t e;
        add("reset0", 1, 0, 0, 0, 0, 0, 0, 32'h3000, 0, 0, 0);
        add("reset1", 1, 0, 1, 32'h3300, 1, 0, 0, 32'h3000, 0, 0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            drive(s);
            e = exp_q.pop_front();
            $display("txn %s pc=%h fv=%b adel=%b pend=%b", s.name, pc, fetch_valid, fetch_adel, redir_pending);
            n_cmp++;
            if ({pc, fetch_valid, fetch_adel, redir_pending} !== e) begin
                n_bad++;
                $display("FAIL %s: got pc=%h fv=%b adel=%b pend=%b, want pc=%h fv=%b adel=%b pend=%b",
                         s.name, pc, fetch_valid, fetch_adel, redir_pending, e.pc, e.fv, e.adel, e.pend);
            end
        end
    endtask

    task automatic test_free_run_branch();
        stim_t s; exp_t e;
        add("boot_exit", 0, 0, 0, 0, 0, 0, 0, 32'h3000, 1, 0, 0);
        add("seq_3004",  0, 0, 0, 0, 0, 0, 0, 32'h3004, 1, 0, 0);
        add("seq_3008",  0, 0, 0, 0, 0, 0, 0, 32'h3008, 1, 0, 0);
        add("seq_300c",  0, 0, 0, 0, 0, 0, 0, 32'h300C, 1, 0, 0);
        add("seq_3010",  0, 0, 0, 0, 0, 0, 0, 32'h3010, 1, 0, 0);
        add("br_3100",   0, 0, 1, 32'h3100, 0, 0, 0, 32'h3100, 1, 0, 0);
        add("seq_3104",  0, 0, 0, 0, 0, 0, 0, 32'h3104, 1, 0, 0);
        add("br_3020",   0, 0, 1, 32'h3020, 0, 0, 0, 32'h3020, 1, 0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            drive(s);
            e = exp_q.pop_front();
            $display("txn %s pc=%h fv=%b adel=%b pend=%b", s.name, pc, fetch_valid, fetch_adel, redir_pending);
            n_cmp++;
            if ({pc, fetch_valid, fetch_adel, redir_pending} !== e) begin
                n_bad++;
                $display("FAIL %s: got pc=%h fv=%b adel=%b pend=%b, want pc=%h fv=%b adel=%b pend=%b",
                         s.name, pc, fetch_valid, fetch_adel, redir_pending, e.pc, e.fv, e.adel, e.pend);
            end
            n_cmp++;
            if (pc_plus4 !== e.pc + 32'd4) begin
                n_bad++;
                $display("FAIL %s_plus4: got %h want %h", s.name, pc_plus4, e.pc + 32'd4);
            end
        end
    endtask

    task automatic test_stall_redirect();
        stim_t s; exp_t e;
        add("stall_br",    0, 1, 1, 32'h3200, 0, 0, 0, 32'h3020, 1, 0, 1);
        add("stall_2",     0, 1, 0, 0, 0, 0, 0, 32'h3020, 1, 0, 1);
        add("stall_3",     0, 1, 0, 0, 0, 0, 0, 32'h3020, 1, 0, 1);
        add("unstall",     0, 0, 0, 0, 0, 0, 0, 32'h3200, 1, 0, 0);
        add("stall_br_a",  0, 1, 1, 32'h3300, 0, 0, 0, 32'h3200, 1, 0, 1);
        add("stall_br_b",  0, 1, 1, 32'h3340, 0, 0, 0, 32'h3200, 1, 0, 1);
        add("unstall_ovw", 0, 0, 0, 0, 0, 0, 0, 32'h3340, 1, 0, 0);
        add("stall_br_c",  0, 1, 1, 32'h3400, 0, 0, 0, 32'h3340, 1, 0, 1);
        add("br_beats_pd", 0, 0, 1, 32'h3500, 0, 0, 0, 32'h3500, 1, 0, 0);
        add("pend_gone",   0, 0, 0, 0, 0, 0, 0, 32'h3504, 1, 0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            drive(s);
            e = exp_q.pop_front();
            $display("txn %s pc=%h fv=%b adel=%b pend=%b", s.name, pc, fetch_valid, fetch_adel, redir_pending);
            n_cmp++;
            if ({pc, fetch_valid, fetch_adel, redir_pending} !== e) begin
                n_bad++;
                $display("FAIL %s: got pc=%h fv=%b adel=%b pend=%b, want pc=%h fv=%b adel=%b pend=%b",
                         s.name, pc, fetch_valid, fetch_adel, redir_pending, e.pc, e.fv, e.adel, e.pend);
            end
        end
    endtask

    task automatic test_exc_eret();
        stim_t s; exp_t e;
        add("stall_br",    0, 1, 1, 32'h3600, 0, 0, 0, 32'h3504, 1, 0, 1);
        add("exc_stall",   0, 1, 0, 0, 1, 0, 0, 32'h4180, 0, 0, 0);
        add("exc_run",     0, 0, 0, 0, 0, 0, 0, 32'h4180, 1, 0, 0);
        add("exc_seq",     0, 0, 0, 0, 0, 0, 0, 32'h4184, 1, 0, 0);
        add("eret",        0, 0, 0, 0, 0, 1, 32'h3024, 32'h3024, 0, 0, 0);
        add("eret_run",    0, 0, 0, 0, 0, 0, 0, 32'h3024, 1, 0, 0);
        add("eret_seq",    0, 0, 0, 0, 0, 0, 0, 32'h3028, 1, 0, 0);
        add("exc_ov_eret", 0, 0, 1, 32'h3100, 1, 1, 32'h3030, 32'h4180, 0, 0, 0);
        add("exc_flush",   0, 0, 0, 0, 1, 0, 0, 32'h4180, 0, 0, 0);
        add("flush_exit",  0, 0, 0, 0, 0, 0, 0, 32'h4180, 1, 0, 0);
        add("eret_stall",  0, 1, 1, 32'h3700, 0, 1, 32'h3040, 32'h3040, 0, 0, 0);
        add("eret_run2",   0, 0, 0, 0, 0, 0, 0, 32'h3040, 1, 0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            drive(s);
            e = exp_q.pop_front();
            $display("txn %s pc=%h fv=%b adel=%b pend=%b", s.name, pc, fetch_valid, fetch_adel, redir_pending);
            n_cmp++;
            if ({pc, fetch_valid, fetch_adel, redir_pending} !== e) begin
                n_bad++;
                $display("FAIL %s: got pc=%h fv=%b adel=%b pend=%b, want pc=%h fv=%b adel=%b pend=%b",
                         s.name, pc, fetch_valid, fetch_adel, redir_pending, e.pc, e.fv, e.adel, e.pend);
            end
        end
    endtask

    task automatic test_adel();
        stim_t s; exp_t e;
        add("misalign",  0, 0, 1, 32'h3002, 0, 0, 0, 32'h3002, 0, 1, 0);
        add("mis_adv",   0, 0, 0, 0, 0, 0, 0, 32'h3006, 0, 1, 0);
        add("above",     0, 0, 1, 32'h7000, 0, 0, 0, 32'h7000, 0, 1, 0);
        add("below",     0, 0, 1, 32'h2FFC, 0, 0, 0, 32'h2FFC, 0, 1, 0);
        add("last_word", 0, 0, 1, 32'h6FFC, 0, 0, 0, 32'h6FFC, 1, 0, 0);
        add("past_last", 0, 0, 0, 0, 0, 0, 0, 32'h7000, 0, 1, 0);
        add("first",     0, 0, 1, 32'h3000, 0, 0, 0, 32'h3000, 1, 0, 0);
        add("top",       0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 0, 1, 0);
        add("wrap",      0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 1, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            drive(s);
            e = exp_q.pop_front();
            $display("txn %s pc=%h fv=%b adel=%b pend=%b", s.name, pc, fetch_valid, fetch_adel, redir_pending);
            n_cmp++;
            if ({pc, fetch_valid, fetch_adel, redir_pending} !== e) begin
                n_bad++;
                $display("FAIL %s: got pc=%h fv=%b adel=%b pend=%b, want pc=%h fv=%b adel=%b pend=%b",
                         s.name, pc, fetch_valid, fetch_adel, redir_pending, e.pc, e.fv, e.adel, e.pend);
            end
            n_cmp++;
            if (pc_plus4 !== e.pc + 32'd4) begin
                n_bad++;
                $display("FAIL %s_plus4: got %h want %h", s.name, pc_plus4, e.pc + 32'd4);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t s; exp_t e;
        add("br_3500",   0, 0, 1, 32'h3500, 0, 0, 0, 32'h3500, 1, 0, 0);
        add("stall_br",  0, 1, 1, 32'h3700, 0, 0, 0, 32'h3500, 1, 0, 1);
        add("rst_exc",   1, 1, 1, 32'h3800, 1, 1, 32'h3900, 32'h3000, 0, 0, 0);
        add("boot_exit", 0, 0, 0, 0, 0, 0, 0, 32'h3000, 1, 0, 0);
        add("seq_3004",  0, 0, 0, 0, 0, 0, 0, 32'h3004, 1, 0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front();
            drive(s);
            e = exp_q.pop_front();
            $display("txn %s pc=%h fv=%b adel=%b pend=%b", s.name, pc, fetch_valid, fetch_adel, redir_pending);
            n_cmp++;
            if ({pc, fetch_valid, fetch_adel, redir_pending} !== e) begin
                n_bad++;
                $display("FAIL %s: got pc=%h fv=%b adel=%b pend=%b, want pc=%h fv=%b adel=%b pend=%b",
                         s.name, pc, fetch_valid, fetch_adel, redir_pending, e.pc, e.fv, e.adel, e.pend);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; br_valid = 1'b0; br_target = '0;
        exc_req = 1'b0; eret_req = 1'b0; epc = '0;
        test_reset();
        test_free_run_branch();
        test_stall_redirect();
        test_exc_eret();
        test_adel();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
